// File: rtl/ula_serial_n_bits_pkg.sv
// Shared definitions for the serial N-bit ULA: slice width, arithmetic
// op codes and controller states.
package ula_pkg;

  localparam int SLICE_W = 4;

  // Arithmetic op codes (m = 0); any other code behaves as OP_INC
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_INC = 4'b0000;
  localparam logic [3:0] OP_DBL = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ula_serial_n_bits_if.sv
// Operand/result handshake bundle for ula_serial_n_bits.
// master = controller side, slave = the ULA itself.
interface ula_serial_n_bits_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       s;
  logic             m;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             c_out;
  logic             overflow;
  logic             a_eq_b;
  logic             zero;

  modport master (
    output in_valid, a, b, s, m, c_in, out_ready,
    input  in_ready, out_valid, f, c_out, overflow, a_eq_b, zero
  );

  modport slave (
    input  in_valid, a, b, s, m, c_in, out_ready,
    output in_ready, out_valid, f, c_out, overflow, a_eq_b, zero
  );
endinterface

// File: rtl/ula_serial_n_bits_slice.sv
// ula_slice_4: combinational 4-bit ALU slice. Arithmetic ops add a
// selected Y operand plus carry-in; logic ops follow the 74181
// active-high function set. c_msb is the carry into bit 3, used by the
// caller to derive signed overflow on the most significant slice.
module ula_slice_4
  import ula_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cin,
  output logic [3:0] f,
  output logic       cout,
  output logic       c_msb,
  output logic       eq
);

  logic [3:0] y;
  logic [3:0] low_sum;
  logic [4:0] sum;

  // Select the Y operand, form the slice sum, then pick arithmetic or logic result
  always_comb begin
    case (s)
      OP_ADD:  y = b;
      OP_SUB:  y = ~b;
      OP_DBL:  y = a;
      default: y = 4'h0;
    endcase

    low_sum = {1'b0, a[2:0]} + {1'b0, y[2:0]} + {3'b000, cin};
    sum     = {1'b0, a} + {1'b0, y} + {4'b0000, cin};

    f     = sum[3:0];
    cout  = sum[4];
    c_msb = low_sum[3];

    if (m) begin
      cout  = 1'b0;
      c_msb = 1'b0;
      case (s)
        4'h0:    f = ~a;
        4'h1:    f = ~(a | b);
        4'h2:    f = ~a & b;
        4'h3:    f = 4'h0;
        4'h4:    f = ~(a & b);
        4'h5:    f = ~b;
        4'h6:    f = a ^ b;
        4'h7:    f = a & ~b;
        4'h8:    f = ~a | b;
        4'h9:    f = ~(a ^ b);
        4'hA:    f = b;
        4'hB:    f = a & b;
        4'hC:    f = 4'hF;
        4'hD:    f = a | ~b;
        4'hE:    f = a | b;
        default: f = a;
      endcase
    end

    eq = (a == b);
  end

endmodule

// File: rtl/ula_serial_n_bits.sv
// ula_serial_n_bits: WIDTH-bit ALU evaluated as WIDTH/4 serial 4-bit
// slices, LSB first, with the inter-slice carry held in a register.
// Operands enter and results leave through valid/ready handshakes.
// Optional macro ULA_LOGIC_FAST_EN: logic-mode operations skip the
// serial phase and complete in a single cycle using replicated slices.
module ula_serial_n_bits
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  ula_serial_n_bits_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  generate
    if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
      $error("ula_serial_n_bits: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [3:0]       s_reg;
  logic             m_reg;
  logic             carry_reg;
  logic             eq_reg;
  logic [WIDTH-1:0] f_reg;
  logic             c_out_reg;
  logic             overflow_reg;
  logic             a_eq_b_reg;
  logic             zero_reg;

  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic             slice_cin;
  logic [3:0]       slice_f;
  logic             slice_cout;
  logic             slice_c_msb;
  logic             slice_eq;
  logic [WIDTH-1:0] f_next;
  logic             last_slice;

  // Pick the current slice operands; SUB needs an inverted borrow-in on slice 0 only
  always_comb begin
    slice_a    = a_reg[{cnt_reg, 2'b00} +: SLICE_W];
    slice_b    = b_reg[{cnt_reg, 2'b00} +: SLICE_W];
    slice_cin  = carry_reg;
    if ((cnt_reg == '0) && !m_reg && (s_reg == OP_SUB)) begin
      slice_cin = ~carry_reg;
    end
    last_slice = (cnt_reg == CNT_W'(NSLICE - 1));
  end

  ula_slice_4 u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .s     (s_reg),
    .m     (m_reg),
    .cin   (slice_cin),
    .f     (slice_f),
    .cout  (slice_cout),
    .c_msb (slice_c_msb),
    .eq    (slice_eq)
  );

  // Result with the current slice merged in, so zero can be judged on the final value
  always_comb begin
    f_next = f_reg;
    f_next[{cnt_reg, 2'b00} +: SLICE_W] = slice_f;
  end

`ifdef ULA_LOGIC_FAST_EN
  logic [WIDTH-1:0]  fast_f;
  logic [NSLICE-1:0] fast_eq;
  logic [NSLICE:0]   fast_c;
  logic [NSLICE-1:0] fast_c_msb;

  assign fast_c[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_fast
      ula_slice_4 u_fast_slice (
        .a     (bus.a[gi*SLICE_W +: SLICE_W]),
        .b     (bus.b[gi*SLICE_W +: SLICE_W]),
        .s     (bus.s),
        .m     (1'b1),
        .cin   (fast_c[gi]),
        .f     (fast_f[gi*SLICE_W +: SLICE_W]),
        .cout  (fast_c[gi+1]),
        .c_msb (fast_c_msb[gi]),
        .eq    (fast_eq[gi])
      );
    end
  endgenerate
`endif

  // Controller: latch in IDLE, one slice per RUN cycle, hold results in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      s_reg        <= 4'h0;
      m_reg        <= 1'b0;
      carry_reg    <= 1'b0;
      eq_reg       <= 1'b0;
      f_reg        <= '0;
      c_out_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      a_eq_b_reg   <= 1'b0;
      zero_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            s_reg     <= bus.s;
            m_reg     <= bus.m;
            carry_reg <= bus.c_in;
            cnt_reg   <= '0;
            eq_reg    <= 1'b1;
`ifdef ULA_LOGIC_FAST_EN
            if (bus.m) begin
              f_reg        <= fast_f;
              c_out_reg    <= fast_c[NSLICE];
              overflow_reg <= fast_c[NSLICE] ^ fast_c_msb[NSLICE-1];
              a_eq_b_reg   <= &fast_eq;
              zero_reg     <= (fast_f == '0);
              state_reg    <= ST_DONE;
            end else begin
              state_reg    <= ST_RUN;
            end
`else
            state_reg <= ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          f_reg     <= f_next;
          carry_reg <= slice_cout;
          eq_reg    <= eq_reg & slice_eq;
          if (last_slice) begin
            c_out_reg    <= slice_cout;
            overflow_reg <= !m_reg && (slice_cout ^ slice_c_msb);
            a_eq_b_reg   <= eq_reg & slice_eq;
            zero_reg     <= (f_next == '0);
            state_reg    <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.out_valid = (state_reg == ST_DONE);
  assign bus.f         = f_reg;
  assign bus.c_out     = c_out_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.a_eq_b    = a_eq_b_reg;
  assign bus.zero      = zero_reg;

endmodule
